isp_boot_controller: RTL
========================

# isp_boot_controller

Boot sequencer for `RISC_V_Core`. It accepts a byte stream from a host link (UART receiver or debug bridge), assembles little-endian 32-bit words, and writes them into program memory through the core's `isp_write`/`isp_address`/`isp_data` port. It then releases the core from reset and pulses `start` with `prog_address`. It sits between the peripheral receive path and the core's reset/start/ISP inputs, replacing the testbench-driven `reset`/`start` sequence in hardware builds.

## Interface
- `DATA_WIDTH`, default 32: ISP data width. Fixed at 32; words are 4 bytes.
- `ADDRESS_BITS`, default 12: ISP word-address width. The maximum image is 2^ADDRESS_BITS words.
- `PROG_ADDRESS`, default 20'h00000: value driven on `prog_address`.
- `START_DELAY`, default 4: cycles between `core_reset` deassertion and the `start` pulse. Must be ≥ 1.
- `TIMEOUT`, default 1024: maximum idle cycles between accepted bytes while receiving.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it (0) forces all state and outputs to their reset values immediately.
- `load_req` in 1: level; starts (or restarts) an image load.
- `run_req` in 1: level; start the core without loading.
- `rx_data` in 8: host byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: byte accepted on a clock edge where `rx_valid & rx_ready`.
- `core_reset` out 1: active-high reset to the core.
- `start` out 1: one-cycle start pulse to the core.
- `prog_address` out 20: constant `PROG_ADDRESS`.
- `isp_write` out 1: program-memory write strobe.
- `isp_address` out ADDRESS_BITS: word index.
- `isp_data` out DATA_WIDTH: assembled word.
- `busy` out 1: load in progress (states HDR0 through START_WAIT).
- `done` out 1: core running (RUN).
- `error` out 1: load aborted (ERR).
- `words_loaded` out 16: count of completed ISP writes in the current load.

## Operation
- Reset values:
  - `core_reset`=1.
  - `start`, `isp_write`, `rx_ready`, `busy`, `done`, `error` = 0.
  - `isp_address`=0, `isp_data`=0, `words_loaded`=0.
  - `prog_address`=`PROG_ADDRESS`.
  - State = IDLE.
- Protocol: 2-byte little-endian word count N, followed by N×4 bytes. Each word is sent little-endian, least-significant byte first.
- States:
  - **IDLE** (`core_reset`=1):
    - `load_req` → HDR0.
    - Otherwise `run_req` → START_WAIT.
    - If both are high, `load_req` wins.
  - **HDR0**: accept byte → N[7:0] → HDR1.
  - **HDR1**: accept byte → N[15:8].
    - N=0 → START_WAIT.
    - N > 2^ADDRESS_BITS → ERR.
    - Otherwise clear the word index and byte index → WORD.
  - **WORD**: accept 4 bytes into byte lanes 0..3. On the 4th byte → WRITE.
  - **WRITE** (`rx_ready`=0):
    - `isp_write`=1 for exactly one cycle, with `isp_address`=word index and `isp_data`=assembled word.
    - Then `words_loaded`+1 and word index+1.
    - → START_WAIT if this was word N-1, else WORD.
  - **START_WAIT**: `core_reset`=0. Count `START_DELAY` cycles → START.
  - **START**: `start`=1 for one cycle → RUN.
  - **RUN**: `done`=1, `core_reset`=0. `load_req` → `core_reset`=1, clear `words_loaded` → HDR0 (reload).
  - **ERR**: `error`=1, `core_reset`=1. `load_req` → HDR0, clearing `error` and `words_loaded`.
- `rx_ready`=1 only in HDR0, HDR1 and WORD (combinational from state).
- Timeout:
  - An idle counter runs in HDR0/HDR1/WORD and clears on every accepted byte.
  - Reaching `TIMEOUT` → ERR. The partial word is discarded and no write is issued.
- N = 2^ADDRESS_BITS is legal: the last write goes to address 2^ADDRESS_BITS−1, and the word index must not wrap before completion.
- A `load_req` in any state other than IDLE/RUN/ERR is ignored.
- `reset` asserted mid-load: outputs return to reset values immediately, with no further ISP writes. The memory keeps any words already written.

## Timing
- A byte is accepted at edge k. The state or lane update is visible in cycle k+1.
- 4th byte of a word at edge k → `isp_write`=1 during cycle k+1, deasserted at k+2. Back-to-back minimum is 5 cycles per word.
- Last write at edge w → `core_reset` falls in cycle w+1 → `start` is high in cycle w+1+`START_DELAY` for exactly one cycle → `done` from the following cycle.
- From IDLE with `run_req`: `core_reset` falls 1 cycle after the sampling edge. `start` follows `START_DELAY` cycles later.
- All outputs except `rx_ready` are registered.

## Test plan
- **Two-word load**: bytes 02 00 13 00 00 00 93 05 A0 00 →
  - writes (addr 0, 32'h00000013) then (addr 1, 32'h00A00593), each a 1-cycle `isp_write`;
  - `words_loaded`=2;
  - `start` pulses 4 cycles after `core_reset` falls;
  - `done`=1, `prog_address`=0.
- **Empty image / `run_req`**: header 00 00, or `run_req` in IDLE → zero ISP writes, single `start` pulse, `done`=1.
- **Oversize header**: 01 10 (N=0x1001, ADDRESS_BITS=12) → `error`=1, no `isp_write`, `core_reset` stays 1. Header 00 10 is accepted.
- **Timeout**: TIMEOUT=16, send 02 00 13 then idle → `error`=1 exactly 16 cycles after the last accepted byte, no write, `rx_ready`=0.
- **Reset mid-load**: `reset`=0 after 6 bytes → all outputs at reset values in the same cycle. After release, a fresh load of 01 00 EF BE AD DE writes 32'hDEADBEEF to addr 0.
- **Reload from RUN and backpressure**: `load_req` while `done`=1 → `core_reset`=1 the next cycle and `done`=0. With `rx_valid` held high, `rx_ready`=0 during each WRITE cycle and no byte is lost.

Source files
------------

// File: rtl/isp_boot_controller.sv
// Boot sequencer: receives a word-count header plus a little-endian word image
// over a byte link, writes it to core program memory, then releases and starts the core.
module isp_boot_controller #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDRESS_BITS = 12,
    parameter logic [19:0] PROG_ADDRESS = 20'h00000,
    parameter int          START_DELAY  = 4,
    parameter int          TIMEOUT      = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_req,
    input  logic                    run_req,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    core_reset,
    output logic                    start,
    output logic [19:0]             prog_address,
    output logic                    isp_write,
    output logic [ADDRESS_BITS-1:0] isp_address,
    output logic [DATA_WIDTH-1:0]   isp_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             words_loaded
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] HDR0       = 4'd1;
    localparam logic [3:0] HDR1       = 4'd2;
    localparam logic [3:0] WORD       = 4'd3;
    localparam logic [3:0] WRITE      = 4'd4;
    localparam logic [3:0] START_WAIT = 4'd5;
    localparam logic [3:0] START      = 4'd6;
    localparam logic [3:0] RUN        = 4'd7;
    localparam logic [3:0] ERR        = 4'd8;

    localparam int          TO_W      = $clog2(TIMEOUT + 1);
    localparam int          SD_W      = $clog2(START_DELAY + 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDRESS_BITS;

    logic [3:0]            state_r;
    logic [3:0]            state_nxt_s;
    logic [7:0]            n_lo_r;
    logic [15:0]           n_r;
    logic [15:0]           n_hdr_s;
    // 17-bit index so an image of exactly 2^ADDRESS_BITS words never wraps early
    logic [16:0]           idx_r;
    logic [1:0]            byte_idx_r;
    logic [DATA_WIDTH-9:0] lanes_r;
    logic [TO_W-1:0]       idle_cnt_r;
    logic [SD_W-1:0]       delay_cnt_r;
    logic                  accept_s;
    logic                  timeout_s;
    logic                  last_word_s;

    assign prog_address = PROG_ADDRESS;
    assign accept_s     = rx_valid & rx_ready;
    assign timeout_s    = rx_ready & ~accept_s & (idle_cnt_r == TO_W'(TIMEOUT - 1));
    assign last_word_s  = (idx_r + 17'd1) == {1'b0, n_r};
    assign n_hdr_s      = {rx_data, n_lo_r};

    // Byte-link handshake: ready only while a header or word byte is expected
    always_comb begin
        rx_ready = 1'b0;
        case (state_r)
            HDR0, HDR1, WORD: rx_ready = 1'b1;
            default:          rx_ready = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_req)     state_nxt_s = HDR0;
                else if (run_req) state_nxt_s = START_WAIT;
                else              state_nxt_s = IDLE;
            end
            HDR0: begin
                if (accept_s)       state_nxt_s = HDR1;
                else if (timeout_s) state_nxt_s = ERR;
                else                state_nxt_s = HDR0;
            end
            HDR1: begin
                if (accept_s) begin
                    if (n_hdr_s == 16'd0)                    state_nxt_s = START_WAIT;
                    else if ({1'b0, n_hdr_s} > MAX_WORDS)    state_nxt_s = ERR;
                    else                                     state_nxt_s = WORD;
                end else if (timeout_s) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = HDR1;
                end
            end
            WORD: begin
                if (accept_s) begin
                    if (byte_idx_r == 2'd3) state_nxt_s = WRITE;
                    else                    state_nxt_s = WORD;
                end else if (timeout_s) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = WORD;
                end
            end
            WRITE: begin
                if (last_word_s) state_nxt_s = START_WAIT;
                else             state_nxt_s = WORD;
            end
            START_WAIT: begin
                if (delay_cnt_r == SD_W'(START_DELAY - 1)) state_nxt_s = START;
                else                                       state_nxt_s = START_WAIT;
            end
            START: state_nxt_s = RUN;
            RUN, ERR: begin
                if (load_req) state_nxt_s = HDR0;
                else          state_nxt_s = state_r;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, counters, header and byte-lane capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            n_lo_r      <= 8'd0;
            n_r         <= 16'd0;
            idx_r       <= 17'd0;
            byte_idx_r  <= 2'd0;
            lanes_r     <= '0;
            idle_cnt_r  <= '0;
            delay_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s || !rx_ready) idle_cnt_r <= '0;
            else                       idle_cnt_r <= idle_cnt_r + TO_W'(1);
            if (state_r == START_WAIT) delay_cnt_r <= delay_cnt_r + SD_W'(1);
            else                       delay_cnt_r <= '0;
            if (accept_s && state_r == HDR0) n_lo_r <= rx_data;
            if (accept_s && state_r == HDR1) begin
                n_r        <= n_hdr_s;
                idx_r      <= 17'd0;
                byte_idx_r <= 2'd0;
            end else if (state_r == WRITE) begin
                idx_r <= idx_r + 17'd1;
            end else if (accept_s && state_r == WORD) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                // the top byte goes straight into isp_data, so only lanes 0..2 are held
                if (byte_idx_r != 2'd3) lanes_r[{byte_idx_r, 3'b000} +: 8] <= rx_data;
            end
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_reset   <= 1'b1;
            start        <= 1'b0;
            isp_write    <= 1'b0;
            isp_address  <= '0;
            isp_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            core_reset <= !(state_nxt_s == START_WAIT || state_nxt_s == START || state_nxt_s == RUN);
            start      <= (state_nxt_s == START);
            isp_write  <= (state_nxt_s == WRITE);
            busy       <= (state_nxt_s == HDR0) || (state_nxt_s == HDR1) || (state_nxt_s == WORD) ||
                          (state_nxt_s == WRITE) || (state_nxt_s == START_WAIT);
            done       <= (state_nxt_s == RUN);
            error      <= (state_nxt_s == ERR);
            if (state_nxt_s == WRITE) begin
                isp_address <= idx_r[ADDRESS_BITS-1:0];
                isp_data    <= {rx_data, lanes_r};
            end
            if (state_nxt_s == HDR0 && state_r != HDR0) words_loaded <= 16'd0;
            else if (state_r == WRITE)                  words_loaded <= words_loaded + 16'd1;
        end
    end

endmodule
